// File: rtl/sseg_scan_ctrl.sv
// Four-digit seven-segment scan scheduler: blank/lit slots per digit, shadow
// digit registers committed to the displayed set at each frame boundary.
//
// state | meaning
// OFF   | display dark, scan parked at digit 0, writes always accepted
// BLANK | first BLANK_CYC cycles of a slot, all anodes off
// SHOW  | rest of the slot, digit idx lit from its active register
module sseg_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic       wr_dp,
  output logic       wr_ready,
  output logic [7:0] seg,
  output logic [3:0] an,
  output logic [1:0] scan_idx,
  output logic       frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  // digit record: [5] = blank, [4:1] = hex value, [0] = dp
  localparam logic [5:0] DIGIT_BLANK = 6'b10_0000;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_SHOW} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [5:0]    shadow [4];
  logic [5:0]    active [4];
  logic [5:0]    digit;
  logic [7:0]    seg_show;
  logic          commit;

  function automatic logic [6:0] hex_dec(input logic [3:0] v);
    case (v)
      4'h0: hex_dec = 7'h40;
      4'h1: hex_dec = 7'h79;
      4'h2: hex_dec = 7'h24;
      4'h3: hex_dec = 7'h30;
      4'h4: hex_dec = 7'h19;
      4'h5: hex_dec = 7'h12;
      4'h6: hex_dec = 7'h02;
      4'h7: hex_dec = 7'h78;
      4'h8: hex_dec = 7'h00;
      4'h9: hex_dec = 7'h10;
      4'hA: hex_dec = 7'h08;
      4'hB: hex_dec = 7'h03;
      4'hC: hex_dec = 7'h46;
      4'hD: hex_dec = 7'h21;
      4'hE: hex_dec = 7'h06;
      default: hex_dec = 7'h0E;
    endcase
  endfunction

  assign digit    = active[idx];
  assign seg_show = {~digit[0], digit[5] ? 7'h7F : hex_dec(digit[4:1])};
  assign commit   = (state == S_BLANK) && (cnt == '0) && (idx == 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_OFF;
      cnt         <= '0;
      idx         <= 2'd0;
      an          <= 4'hF;
      seg         <= 8'hFF;
      scan_idx    <= 2'd0;
      frame_start <= 1'b0;
      wr_ready    <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        shadow[i] <= DIGIT_BLANK;
        active[i] <= DIGIT_BLANK;
      end
    end else begin
      // display outputs trail the state register by one cycle
      an       <= (state == S_SHOW) ? ~(4'b0001 << idx) : 4'hF;
      seg      <= (state == S_SHOW) ? seg_show : 8'hFF;
      scan_idx <= idx;

      if (commit) begin
        for (int i = 0; i < 4; i++) active[i] <= shadow[i];
      end
      if (wr_en && wr_ready) shadow[wr_addr] <= {wr_data, wr_dp};

      // frame_start / wr_ready are set on entry so they coincide with the commit cycle
      frame_start <= 1'b0;
      wr_ready    <= 1'b1;
      case (state)
        S_OFF: begin
          state       <= S_BLANK;
          cnt         <= '0;
          idx         <= 2'd0;
          frame_start <= 1'b1;
          wr_ready    <= 1'b0;
        end
        S_BLANK: begin
          cnt <= cnt + 1'b1;
          if (cnt == BLANK_LAST) state <= S_SHOW;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= idx + 1'b1;
            if (idx == 2'd3) begin
              frame_start <= 1'b1;
              wr_ready    <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      if (!enable) begin
        state       <= S_OFF;
        cnt         <= '0;
        idx         <= 2'd0;
        frame_start <= 1'b0;
        wr_ready    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Bench for sseg_scan_ctrl: directed scenarios plus random writes, checked
// every cycle against a frame-time reference model.
module tb_sseg_scan_ctrl;
  localparam int S = 8;
  localparam int B = 2;
  localparam int FRAME = 4 * S;

  logic       clock = 1'b0;
  logic       reset, enable, wr_en, wr_dp;
  logic [1:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_ready, frame_start;
  logic [7:0] seg;
  logic [3:0] an;
  logic [1:0] scan_idx;

  sseg_scan_ctrl #(.SCAN_DIV(S), .BLANK_CYC(B)) dut (
    .clock(clock), .reset(reset), .enable(enable), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp), .wr_ready(wr_ready),
    .seg(seg), .an(an), .scan_idx(scan_idx), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // model: running flag plus time since the last frame commit
  bit         m_run;
  int         m_t;
  logic [5:0] m_shadow [4];
  logic [5:0] m_active [4];
  logic [3:0] e_an, prev_an;
  logic [7:0] e_seg;
  logic [1:0] e_idx;
  logic       e_fs, e_rdy;
  logic [6:0] hex_tab [16];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    int di, dc;
    @(posedge clock);
    if (reset) begin
      m_run = 1'b0;
      m_t   = 0;
      for (int i = 0; i < 4; i++) begin
        m_shadow[i] = 6'h20;
        m_active[i] = 6'h20;
      end
      e_an = 4'hF; e_seg = 8'hFF; e_idx = 2'd0; e_fs = 1'b0; e_rdy = 1'b1;
    end else begin
      di = (m_t / S) % 4;
      dc = m_t % S;
      if (m_run && dc >= B) begin
        e_an  = ~(4'b0001 << di);
        e_seg = {~m_active[di][0], m_active[di][5] ? 7'h7F : hex_tab[m_active[di][4:1]]};
      end else begin
        e_an  = 4'hF;
        e_seg = 8'hFF;
      end
      e_idx = m_run ? 2'(di) : 2'd0;
      if (m_run && m_t == 0) m_active = m_shadow;
      if (wr_en && e_rdy) m_shadow[wr_addr] = {wr_data, wr_dp};
      if (!enable) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
      e_fs  = m_run && (m_t == 0);
      e_rdy = !e_fs;
    end
    #1;
    check("an", 8'(an), 8'(e_an));
    check("seg", seg, e_seg);
    check("scan_idx", 8'(scan_idx), 8'(e_idx));
    check("frame_start", 8'(frame_start), 8'(e_fs));
    check("wr_ready", 8'(wr_ready), 8'(e_rdy));
    check("an_onehot", 8'($countones(~an) <= 1), 8'd1);
    check("an_gap", 8'(an == 4'hF || prev_an == 4'hF || an == prev_an), 8'd1);
    prev_an = an;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic write(input logic [1:0] a, input logic [4:0] d, input logic dp);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_dp = dp;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] pat, input string tag);
    for (int i = 0; i < 100 && an !== pat; i++) cycle();
    check(tag, 8'(an), 8'(pat));
  endtask

  task automatic random_cycles(input int n, input bit toggle_en);
    for (int i = 0; i < n; i++) begin
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 2'($urandom_range(0, 3));
      wr_data = 5'($urandom_range(0, 31));
      wr_dp   = 1'($urandom_range(0, 1));
      if (toggle_en && $urandom_range(0, 39) == 0) enable = ~enable;
      cycle();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    prev_an = 4'hF;
    reset = 1'b1; enable = 1'b0; wr_en = 1'b0;
    wr_addr = 2'd0; wr_data = 5'd0; wr_dp = 1'b0;
    run(3);
    reset = 1'b0;
    run(20);

    write(2'd0, 5'h05, 1'b0);
    write(2'd1, 5'h0A, 1'b1);
    write(2'd2, 5'h10, 1'b0);
    write(2'd3, 5'h00, 1'b0);
    enable = 1'b1;
    run(70);

    // change digit 0 mid-frame; old value stays until the next commit
    wait_an(4'b1101, "wait_d1");
    write(2'd0, 5'h07, 1'b0);
    run(40);

    // request held through the commit cycle
    for (int i = 0; i < 100 && frame_start !== 1'b1; i++) cycle();
    check("wait_fs", 8'(frame_start), 8'd1);
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 5'h03; wr_dp = 1'b0;
    cycle();
    cycle();
    wr_en = 1'b0;
    run(40);

    wait_an(4'b1011, "wait_d2");
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(40);

    wait_an(4'b1110, "wait_d0");
    wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h04; wr_dp = 1'b1;
    reset = 1'b1;
    cycle();
    reset = 1'b0; wr_en = 1'b0;
    run(40);

    random_cycles(300, 1'b1);
    enable = 1'b1;
    random_cycles(1000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
